// File: rtl/udc_param.sv
// Parametrised up/down counter (wrap or saturate, synchronous load) with a
// registered, multiplexed hexadecimal 7-segment display scanner.
module udc_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int SCAN_DIV = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     updown,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_value,
    output logic [WIDTH-1:0]         out,
    output logic                     outw,
    output logic [(WIDTH+3)/4-1:0]   an,
    output logic [6:0]               seg,
    output logic                     dp
);

    localparam int DIGITS = (WIDTH + 3) / 4;
    localparam int SW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [WIDTH:0]  TOP        = (WIDTH+1)'(MODULUS - 1);
    localparam logic [SW-1:0]   SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DIGIT_LAST = DW'(DIGITS - 1);

    logic [WIDTH-1:0]  count_q, count_d;
    logic              outw_q, outw_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              updown_q, updown_d;

    logic [WIDTH:0]      cnt_ext;
    logic [WIDTH:0]      ld_ext;
    logic [DIGITS*4-1:0] padded;
    logic [3:0]          nibble;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    hex_glyph = 7'b1111110;
            4'h1:    hex_glyph = 7'b0110000;
            4'h2:    hex_glyph = 7'b1101101;
            4'h3:    hex_glyph = 7'b1111001;
            4'h4:    hex_glyph = 7'b0110011;
            4'h5:    hex_glyph = 7'b1011011;
            4'h6:    hex_glyph = 7'b1011111;
            4'h7:    hex_glyph = 7'b1110000;
            4'h8:    hex_glyph = 7'b1111111;
            4'h9:    hex_glyph = 7'b1111011;
            4'hA:    hex_glyph = 7'b1110111;
            4'hB:    hex_glyph = 7'b0011111;
            4'hC:    hex_glyph = 7'b1001110;
            4'hD:    hex_glyph = 7'b0111101;
            4'hE:    hex_glyph = 7'b1001111;
            default: hex_glyph = 7'b1000111;
        endcase
    endfunction

    // Bound checks use WIDTH+1 bits so MODULUS = 2^WIDTH cannot alias to 0.
    always_comb begin
        cnt_ext = {1'b0, count_q};
        ld_ext  = {1'b0, load_value};
        count_d = count_q;
        outw_d  = 1'b0;
        if (load) begin
            count_d = (ld_ext > TOP) ? TOP[WIDTH-1:0] : load_value;
        end else if (enable) begin
            if (updown) begin
                outw_d = (cnt_ext == TOP);
                if (cnt_ext == TOP) begin
                    count_d = (SATURATE != 0) ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                outw_d = (cnt_ext == '0);
                if (cnt_ext == '0) begin
                    count_d = (SATURATE != 0) ? count_q : TOP[WIDTH-1:0];
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        scan_d  = scan_q + SW'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
        end
    end

    // Display registers sample the current count and digit, one cycle behind.
    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = count_q;
        nibble             = '0;
        an_d               = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                nibble  = padded[i*4 +: 4];
                an_d[i] = 1'b1;
            end
        end
        seg_d    = hex_glyph(nibble);
        dp_d     = (digit_q == '0) && !updown_q;
        updown_d = updown;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            outw_q   <= 1'b0;
            scan_q   <= '0;
            digit_q  <= '0;
            an_q     <= DIGITS'(1);
            seg_q    <= 7'b1111110;
            dp_q     <= 1'b0;
            updown_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            outw_q   <= outw_d;
            scan_q   <= scan_d;
            digit_q  <= digit_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            updown_q <= updown_d;
        end
    end

    assign out  = count_q;
    assign outw = outw_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_udc_param.sv
// Bench for udc_param: wrap, saturate and multi-digit instances driven from
// vector tables through a scoreboard queue, plus scan and async-reset sequences.
module tb_udc_param;

    typedef struct {
        logic       ld;
        logic       en;
        logic       ud;
        logic [3:0] lv;
        logic [3:0] eo;
        logic       ew;
    } vec_t;

    typedef struct {
        int         inst;
        int         idx;
        logic [3:0] eo;
        logic       ew;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       w_load = 1'b0, w_en = 1'b0, w_ud = 1'b1;
    logic [3:0] w_lv = '0;
    logic [3:0] w_out;
    logic       w_outw, w_dp;
    logic [0:0] w_an;
    logic [6:0] w_seg;

    logic       s_load = 1'b0, s_en = 1'b0, s_ud = 1'b1;
    logic [3:0] s_lv = '0;
    logic [3:0] s_out;
    logic       s_outw, s_dp;
    logic [0:0] s_an;
    logic [6:0] s_seg;

    logic       m_load = 1'b0, m_en = 1'b0, m_ud = 1'b1;
    logic [7:0] m_lv = '0;
    logic [7:0] m_out;
    logic       m_outw, m_dp;
    logic [1:0] m_an;
    logic [6:0] m_seg;

    int n_chk = 0;
    int n_fail = 0;

    vec_t wtab[23];
    vec_t stab[9];
    exp_t sb[$];

    always #5 clk = ~clk;

    udc_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .SCAN_DIV(2)) u_wrap (
        .clock(clk), .reset(reset), .enable(w_en), .updown(w_ud), .load(w_load),
        .load_value(w_lv), .out(w_out), .outw(w_outw), .an(w_an), .seg(w_seg), .dp(w_dp)
    );

    udc_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .SCAN_DIV(2)) u_sat (
        .clock(clk), .reset(reset), .enable(s_en), .updown(s_ud), .load(s_load),
        .load_value(s_lv), .out(s_out), .outw(s_outw), .an(s_an), .seg(s_seg), .dp(s_dp)
    );

    udc_param #(.WIDTH(8), .MODULUS(200), .SATURATE(0), .SCAN_DIV(4)) u_mux (
        .clock(clk), .reset(reset), .enable(m_en), .updown(m_ud), .load(m_load),
        .load_value(m_lv), .out(m_out), .outw(m_outw), .an(m_an), .seg(m_seg), .dp(m_dp)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input int inst, input vec_t v, input int idx);
        exp_t e;
        logic [3:0] act_o;
        logic act_w;
        w_load = 1'b0; w_en = 1'b0;
        s_load = 1'b0; s_en = 1'b0;
        if (inst == 0) begin
            w_load = v.ld; w_en = v.en; w_ud = v.ud; w_lv = v.lv;
        end else begin
            s_load = v.ld; s_en = v.en; s_ud = v.ud; s_lv = v.lv;
        end
        sb.push_back('{inst, idx, v.eo, v.ew});
        @(posedge clk); #1;
        e = sb.pop_front();
        act_o = (e.inst == 0) ? w_out : s_out;
        act_w = (e.inst == 0) ? w_outw : s_outw;
        chk($sformatf("out[%0d.%0d]", e.inst, e.idx), 32'(act_o), 32'(e.eo));
        chk($sformatf("outw[%0d.%0d]", e.inst, e.idx), 32'(act_w), 32'(e.ew));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] prev_an;
        logic [6:0] exp_seg;
        int run;
        int trans;

        // Wrap instance: 12 up steps, then down through the 0 -> 9 wrap.
        for (int i = 0; i < 12; i++)
            wtab[i] = '{1'b0, 1'b1, 1'b1, 4'd0, 4'((i + 1) % 10), (((i + 1) % 10) == 0)};
        wtab[12] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0};
        wtab[13] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd9, 1'b1};
        wtab[14] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd8, 1'b0};
        wtab[15] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd7, 1'b0};
        wtab[16] = '{1'b1, 1'b1, 1'b1, 4'd15, 4'd9, 1'b0};
        wtab[17] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b1};
        wtab[18] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0};
        wtab[19] = '{1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0};
        wtab[20] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd6, 1'b0};
        wtab[21] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd5, 1'b0};
        wtab[22] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd6, 1'b0};

        stab[0] = '{1'b1, 1'b0, 1'b1, 4'd8,  4'd8, 1'b0};
        stab[1] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd9, 1'b0};
        stab[2] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd9, 1'b1};
        stab[3] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd9, 1'b1};
        stab[4] = '{1'b1, 1'b0, 1'b0, 4'd1,  4'd1, 1'b0};
        stab[5] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0};
        stab[6] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1};
        stab[7] = '{1'b1, 1'b1, 1'b1, 4'd15, 4'd9, 1'b0};
        stab[8] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd9, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_out", 32'(w_out), 0);
        chk("rst_w_outw", 32'(w_outw), 0);
        chk("rst_w_an", 32'(w_an), 1);
        chk("rst_w_seg", 32'(w_seg), 32'(7'b1111110));
        chk("rst_w_dp", 32'(w_dp), 0);
        chk("rst_m_out", 32'(m_out), 0);
        chk("rst_m_an", 32'(m_an), 1);
        chk("rst_m_seg", 32'(m_seg), 32'(7'b1111110));
        chk("rst_s_out", 32'(s_out), 0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            apply(0, wtab[i], i);
            if (i == 15) begin
                chk("wrap_down_dp", 32'(w_dp), 1);
                chk("wrap_down_an", 32'(w_an), 1);
                chk("wrap_seg_lag", 32'(w_seg), 32'(7'b1111111));
            end
        end
        w_en = 1'b0; w_load = 1'b0; w_ud = 1'b1;

        for (int i = 0; i < 9; i++) apply(1, stab[i], i);
        s_en = 1'b0; s_load = 1'b0;

        // Two-digit scan: each digit holds for exactly 4 cycles after 0xAB is loaded.
        m_load = 1'b1; m_lv = 8'hAB;
        @(posedge clk); #1;
        m_load = 1'b0;
        chk("mux_load", 32'(m_out), 32'hAB);
        repeat (2) @(posedge clk);
        #1;
        prev_an = m_an;
        run = 1;
        trans = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            chk("mux_an_onehot", 32'((m_an == 2'b01) || (m_an == 2'b10)), 1);
            exp_seg = (m_an == 2'b01) ? 7'b0011111 : 7'b1110111;
            chk("mux_seg", 32'(m_seg), 32'(exp_seg));
            chk("mux_dp", 32'(m_dp), 0);
            if (m_an != prev_an) begin
                if (trans > 0) chk("mux_dwell", 32'(run), 4);
                trans++;
                run = 1;
            end else begin
                run++;
            end
            prev_an = m_an;
        end
        chk("mux_transitions", 32'(trans >= 5), 1);

        // Asynchronous reset between edges with out = 7 on digit 1.
        m_load = 1'b1; m_lv = 8'd7;
        @(posedge clk); #1;
        m_load = 1'b0;
        chk("areset_pre_out", 32'(m_out), 7);
        for (int k = 0; k < 20 && m_an != 2'b10; k++) begin
            @(posedge clk); #1;
        end
        chk("areset_pre_an", 32'(m_an), 2);
        #3;
        reset = 1'b0;
        #1;
        chk("areset_out", 32'(m_out), 0);
        chk("areset_an", 32'(m_an), 1);
        chk("areset_seg", 32'(m_seg), 32'(7'b1111110));
        chk("areset_outw", 32'(m_outw), 0);
        chk("areset_w_out", 32'(w_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
